uart_tx_sched: RTL and testbench

//  Shares the single UART byte transmitter between NREQ byte-stream requesters (core, debug, status).
//  - Round-robin grant; the grant is held until s_tlast, so messages never interleave.
//  - With EMIT_TAG=1, each message is preceded by a one-byte channel tag.
//  - Sits between the requesters and the transmitter's tdata/tvalid/tready input.

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_sched.sv | 111 +++++++++++
 tb/tb_uart_tx_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TAG,
        DATA
    } sched_state_t;

    localparam logic [7:0] UART_TAG_BASE = 8'hF0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after i_last, wrapping mod N.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_any
);

    logic [IDW:0] w_sum;

    assign o_any = |i_req;

    // Walk offsets from far to near so the nearest requester after i_last wins.
    always_comb begin
        o_gnt_id = '0;
        w_sum    = '0;
        for (int k = int'(N); k >= 1; k--) begin
            w_sum = {1'b0, i_last} + (IDW + 1)'(k);
            if (w_sum >= (IDW + 1)'(N)) begin
                w_sum = w_sum - (IDW + 1)'(N);
            end
            if (i_req[w_sum[IDW-1:0]]) begin
                o_gnt_id = w_sum[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between NREQ byte streams,
// optionally prefixing each message with a channel tag byte.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter bit          EMIT_TAG = 1'b1,
    parameter logic [7:0]  TAG_BASE = UART_TAG_BASE,
    localparam int unsigned IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ*8-1:0] s_tdata,
    input  logic [NREQ-1:0]   s_tvalid,
    input  logic [NREQ-1:0]   s_tlast,
    output logic [NREQ-1:0]   s_tready,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    sched_state_t   r_state, w_state_d;
    logic [IDW-1:0] r_grant, w_grant_d;
    logic [IDW-1:0] r_last_grant, w_last_grant_d;
    logic [7:0]     r_mdata, w_load_data;
    logic           r_mvalid;
    logic           w_load;
    logic           w_can_load;
    logic [IDW-1:0] w_arb_id;
    logic           w_arb_any;
    logic           w_g_valid;
    logic           w_g_last;
    logic [7:0]     w_g_data;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .i_req    (s_tvalid),
        .i_last   (r_last_grant),
        .o_gnt_id (w_arb_id),
        .o_any    (w_arb_any)
    );

    assign w_can_load = !r_mvalid || m_tready;
    assign w_g_valid  = s_tvalid[r_grant];
    assign w_g_last   = s_tlast[r_grant];
    assign w_g_data   = s_tdata[{r_grant, 3'b000} +: 8];

    assign s_tready = (r_state == DATA && w_can_load) ? (NREQ'(1) << r_grant) : '0;
    assign m_tdata  = r_mdata;
    assign m_tvalid = r_mvalid;
    assign busy     = (r_state != IDLE) || r_mvalid;
    assign grant_id = r_grant;

    always_comb begin
        w_state_d      = r_state;
        w_grant_d      = r_grant;
        w_last_grant_d = r_last_grant;
        w_load         = 1'b0;
        w_load_data    = r_mdata;
        unique case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_grant_d = w_arb_id;
                    w_state_d = EMIT_TAG ? TAG : DATA;
                end
            end
            TAG: begin
                if (w_can_load) begin
                    w_load      = 1'b1;
                    w_load_data = TAG_BASE | 8'(r_grant);
                    w_state_d   = DATA;
                end
            end
            DATA: begin
                if (w_g_valid && w_can_load) begin
                    w_load      = 1'b1;
                    w_load_data = w_g_data;
                    if (w_g_last) begin
                        w_last_grant_d = r_grant;
                        w_state_d      = IDLE;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_mdata      <= 8'h00;
            r_mvalid     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_grant      <= w_grant_d;
            r_last_grant <= w_last_grant_d;
            if (w_load) begin
                r_mdata  <= w_load_data;
                r_mvalid <= 1'b1;
            end else if (m_tready) begin
                r_mvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench: a tagged and an untagged scheduler, exercised one at a time, with the
// expected byte stream derived from per-requester message queues and round-robin order.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tlast;
    logic        m_tready;

    logic [3:0] t_svalid, t_sready, n_svalid, n_sready, cur_sready;
    logic [7:0] t_mdata, n_mdata, cur_mdata;
    logic       t_mready, n_mready, t_mvalid, n_mvalid, cur_mvalid;
    logic       t_busy, n_busy, cur_busy;
    logic [1:0] t_gid, n_gid;

    always #5 clk = ~clk;

    assign t_svalid   = sel ? 4'b0 : s_tvalid;
    assign n_svalid   = sel ? s_tvalid : 4'b0;
    assign t_mready   = sel ? 1'b0 : m_tready;
    assign n_mready   = sel ? m_tready : 1'b0;
    assign cur_sready = sel ? n_sready : t_sready;
    assign cur_mdata  = sel ? n_mdata : t_mdata;
    assign cur_mvalid = sel ? n_mvalid : t_mvalid;
    assign cur_busy   = sel ? n_busy : t_busy;

    uart_tx_sched #(.NREQ(4), .EMIT_TAG(1'b1), .TAG_BASE(8'hF0)) dut_t (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(t_svalid), .s_tlast(s_tlast),
        .s_tready(t_sready), .m_tdata(t_mdata), .m_tvalid(t_mvalid), .m_tready(t_mready),
        .busy(t_busy), .grant_id(t_gid)
    );

    uart_tx_sched #(.NREQ(4), .EMIT_TAG(1'b0), .TAG_BASE(8'hF0)) dut_n (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(n_svalid), .s_tlast(s_tlast),
        .s_tready(n_sready), .m_tdata(n_mdata), .m_tvalid(n_mvalid), .m_tready(n_mready),
        .busy(n_busy), .grant_id(n_gid)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem_d[4][32];
    logic       mem_l[4][32];
    int         cnt[4], ptr[4];
    int         ml[2];
    logic [3:0] acc;
    logic       mon_en, gap_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        mem_d[r][cnt[r]] = d;
        mem_l[r][cnt[r]] = l;
        cnt[r]++;
    endtask

    task automatic add_random(input int max_msgs);
        int nm, len;
        for (int r = 0; r < 4; r++) begin
            nm = $urandom_range(0, max_msgs);
            for (int m = 0; m < nm; m++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) add_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
            end
        end
    endtask

    // Reference: whole messages in round-robin order over requesters with pending work.
    task automatic build_expected();
        int  mp[4];
        int  g, c;
        bit  found;
        for (int i = 0; i < 4; i++) mp[i] = ptr[i];
        forever begin
            found = 1'b0;
            g = 0;
            for (int k = 1; k <= 4; k++) begin
                c = (ml[sel] + k) % 4;
                if (!found && mp[c] < cnt[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
            if (!found) break;
            if (sel == 1'b0) exp_q.push_back(8'hF0 | 8'(g));
            do begin
                exp_q.push_back(mem_d[g][mp[g]]);
                mp[g]++;
            end while (!mem_l[g][mp[g]-1]);
            ml[sel] = g;
        end
    endtask

    task automatic run_phase(input int max_cyc, input int stall_len, input bit gaps,
                             input bit rnd_ready, input int abort_at, input bit lat_chk);
        int  cyc = 0;
        int  first_v = -1;
        int  stall_left = 0;
        bit  stall_started = 1'b0;
        bit  mid, done;
        build_expected();
        acc = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (acc[i]) ptr[i]++;
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (ptr[i] < cnt[i]) begin
                    done = 1'b0;
                    mid = ptr[i] > 0 && !mem_l[i][ptr[i]-1];
                    s_tdata[8*i +: 8] = mem_d[i][ptr[i]];
                    s_tlast[i]        = mem_l[i][ptr[i]];
                    s_tvalid[i]       = !(gaps && mid && $urandom_range(0, 2) == 0);
                end else begin
                    s_tdata[8*i +: 8] = 8'h00;
                    s_tlast[i]        = 1'b0;
                    s_tvalid[i]       = 1'b0;
                end
            end
            if (done && exp_q.size() == 0 && !cur_busy) break;
            if (cur_mvalid && !stall_started && stall_len > 0) begin
                stall_started = 1'b1;
                stall_left    = stall_len;
            end
            if (stall_left > 0) begin
                m_tready = 1'b0;
                stall_left--;
            end else begin
                m_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            acc = cur_sready & s_tvalid;
            if (first_v < 0 && cur_mvalid) first_v = cyc;
            if (abort_at > 0 && cyc == abort_at) return;
            cyc++;
            if (cyc > max_cyc) begin
                chk("phase_timeout", 32'(cyc), 32'(max_cyc));
                break;
            end
        end
        if (lat_chk) chk("first_latency", 32'(first_v), 32'd2);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        s_tvalid = '0;
        m_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            ptr[i] = 0;
        end
        acc = '0;
        ml  = '{3, 3};
        #1;
    endtask

    // Monitor: pops one expected byte per observed transfer; checks stall behaviour.
    logic [7:0] stall_data;
    bit         stall_pend = 1'b0;
    int         since = -1;
    always @(negedge clk) begin
        #2;
        if (!rst && mon_en) begin
            if (stall_pend) begin
                chk("stall_hold_valid", 32'(cur_mvalid), 32'd1);
                chk("stall_hold_data", 32'(cur_mdata), 32'(stall_data));
            end
            stall_pend = cur_mvalid && !m_tready;
            if (stall_pend) begin
                stall_data = cur_mdata;
                chk("stall_sready", 32'(cur_sready), 32'd0);
            end
            if (!gap_chk) since = -1;
            if (cur_mvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(cur_mdata), 32'h100);
                end else begin
                    chk("stream_byte", 32'(cur_mdata), 32'(exp_q.pop_front()));
                end
                if (gap_chk && since >= 0) chk("b2b_gap_le1", 32'(since > 1), 32'd0);
                if (gap_chk) since = 0;
            end else if (since >= 0) begin
                since++;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    initial begin
        rst      = 1'b1;
        sel      = 1'b0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        mon_en   = 1'b0;
        gap_chk  = 1'b0;
        acc      = '0;
        ml       = '{3, 3};
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            ptr[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_t_mvalid", 32'(t_mvalid), 32'd0);
        chk("rst_t_mdata", 32'(t_mdata), 32'h00);
        chk("rst_t_sready", 32'(t_sready), 32'd0);
        chk("rst_t_gid", 32'(t_gid), 32'd0);
        chk("rst_t_busy", 32'(t_busy), 32'd0);
        chk("rst_n_mvalid", 32'(n_mvalid), 32'd0);
        chk("rst_n_gid", 32'(n_gid), 32'd0);
        mon_en = 1'b1;

        // Single tagged message from requester 1.
        add_byte(1, 8'h41, 1'b0);
        add_byte(1, 8'h42, 1'b1);
        run_phase(100, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("t1_grant_id", 32'(t_gid), 32'd1);
        chk("t1_busy", 32'(t_busy), 32'd0);

        // Two requesters together, requester 0 re-requesting.
        add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hB0, 1'b1);
        add_byte(0, 8'hC0, 1'b0); add_byte(0, 8'hD0, 1'b1);
        add_byte(2, 8'hA2, 1'b0); add_byte(2, 8'hB2, 1'b1);
        run_phase(200, 0, 1'b0, 1'b0, 0, 1'b0);

        // Long output stall.
        add_random(2);
        add_byte(3, 8'h5A, 1'b1);
        run_phase(2000, 20, 1'b0, 1'b1, 0, 1'b0);

        // Grant holder drops valid mid-message while another waits.
        for (int b = 0; b < 6; b++) add_byte(3, 8'(8'h30 + b), b == 5);
        add_byte(1, 8'h11, 1'b0); add_byte(1, 8'h12, 1'b1);
        for (int b = 0; b < 4; b++) add_byte(3, 8'(8'h38 + b), b == 3);
        add_byte(1, 8'h13, 1'b1);
        run_phase(2000, 0, 1'b1, 1'b1, 0, 1'b0);

        for (int p = 0; p < 5; p++) begin
            add_random(3);
            run_phase(3000, 0, 1'b1, 1'b1, 0, 1'b0);
        end

        // Reset in the middle of a message.
        for (int b = 0; b < 8; b++) add_byte(2, 8'(8'h60 + b), b == 7);
        run_phase(200, 0, 1'b0, 1'b0, 5, 1'b0);
        chk("pre_rst_mvalid", 32'(t_mvalid), 32'd1);
        do_reset();
        chk("post_rst_mvalid", 32'(t_mvalid), 32'd0);
        chk("post_rst_sready", 32'(t_sready), 32'd0);
        add_byte(3, 8'h73, 1'b1);
        add_byte(0, 8'h70, 1'b0); add_byte(0, 8'h71, 1'b1);
        run_phase(200, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("post_rst_last_grant", 32'(t_gid), 32'd3);

        // Untagged scheduler.
        sel = 1'b1;
        add_byte(2, 8'h55, 1'b1);
        run_phase(100, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("t6_grant_id", 32'(n_gid), 32'd2);
        gap_chk = 1'b1;
        for (int m = 0; m < 3; m++) begin
            add_byte(0, 8'(8'h80 + m), 1'b1);
            add_byte(1, 8'(8'h90 + m), 1'b0);
            add_byte(1, 8'(8'hA0 + m), 1'b1);
        end
        run_phase(300, 0, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        gap_chk = 1'b0;
        for (int p = 0; p < 3; p++) begin
            add_random(3);
            run_phase(3000, 0, 1'b1, 1'b1, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
